// File: rtl/sample_uart_framer_pkg.sv
// Shared types and constants for the sample UART framer.
// Optional feature macro: FRAMER_CHECKSUM_EN (adds a CHK byte and state).
package framer_pkg;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         SEQ_W             = 4;

`ifdef FRAMER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_HI   = 3'd2,
        ST_LO   = 3'd3,
        ST_CHK  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_HI   = 3'd2,
        ST_LO   = 3'd3
    } state_t;
`endif

    // HI byte carries the frame counter and the two top sample bits, no sign extension
    function automatic logic [7:0] hi_byte(input logic [SEQ_W-1:0] seq,
                                           input logic [9:0]       s);
        return {seq, 2'b00, s[9:8]};
    endfunction

`ifdef FRAMER_CHECKSUM_EN
    // Frame check byte: XOR of every byte that precedes it
    function automatic logic [7:0] chk_byte(input logic [7:0] sync_b,
                                            input logic [7:0] hi_b,
                                            input logic [7:0] lo_b);
        return sync_b ^ hi_b ^ lo_b;
    endfunction
`endif

endpackage

// File: rtl/sample_uart_framer_if.sv
// Byte stream towards the UART transmitter (valid/ready handshake).
interface sample_uart_framer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/sample_uart_framer_sample_fifo.sv
// Small synchronous FIFO holding 10-bit samples; read data is the head entry
// (first-word fall-through) so the framer can pop and capture in one edge.
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int         AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      level_r;
    logic             push_s;
    logic             pop_s;

    assign full    = (level_r == FULL_LEVEL);
    assign empty   = (level_r == '0);
    assign push_s  = push && !full;
    assign pop_s   = pop && !empty;
    assign rd_data = mem_r[rd_ptr_r];
    assign level   = level_r;

    // Storage, pointers and occupancy; full is judged on start-of-cycle level
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end
endmodule

// File: rtl/sample_uart_framer.sv
// Buffers waveform samples and emits SYNC/HI/LO byte frames to the UART TX.
// Optional feature macro: FRAMER_CHECKSUM_EN (appends CHK = SYNC^HI^LO).
module sample_uart_framer
    import framer_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ce,
    input  logic [9:0]                    sample,
    sample_uart_framer_if.master          tx,
    output logic                          ovf_pulse,
    output logic                          ovf_flag,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    state_t           state_r;
    logic [SEQ_W-1:0] seq_r;
    logic [9:0]       frame_r;
    logic [7:0]       tx_data_r;
    logic             tx_valid_r;
    logic             ovf_pulse_r;
    logic             ovf_flag_r;

    logic [9:0]       fifo_rd_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             pop_s;
    logic             drop_s;
    logic             accept_s;

    assign pop_s    = (state_r == ST_IDLE) && !fifo_empty_s;
    assign drop_s   = ce && fifo_full_s;
    assign accept_s = tx_valid_r && tx.tx_ready;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (10)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (ce),
        .pop     (pop_s),
        .wr_data (sample),
        .rd_data (fifo_rd_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level)
    );

    // Frame sequencer with registered byte outputs, frame counter and drop tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            seq_r       <= '0;
            frame_r     <= '0;
            tx_data_r   <= 8'h00;
            tx_valid_r  <= 1'b0;
            ovf_pulse_r <= 1'b0;
            ovf_flag_r  <= 1'b0;
        end else begin
            ovf_pulse_r <= drop_s;
            ovf_flag_r  <= ovf_flag_r | drop_s;
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        frame_r    <= fifo_rd_s;
                        tx_data_r  <= SYNC_BYTE;
                        tx_valid_r <= 1'b1;
                        state_r    <= ST_SYNC;
                    end else begin
                        tx_valid_r <= 1'b0;
                    end
                end
                ST_SYNC: begin
                    if (accept_s) begin
                        tx_data_r <= hi_byte(seq_r, frame_r);
                        state_r   <= ST_HI;
                    end else begin
                        state_r   <= ST_SYNC;
                    end
                end
                ST_HI: begin
                    if (accept_s) begin
                        tx_data_r <= frame_r[7:0];
                        state_r   <= ST_LO;
                    end else begin
                        state_r   <= ST_HI;
                    end
                end
`ifdef FRAMER_CHECKSUM_EN
                ST_LO: begin
                    if (accept_s) begin
                        tx_data_r <= chk_byte(SYNC_BYTE, hi_byte(seq_r, frame_r), frame_r[7:0]);
                        state_r   <= ST_CHK;
                    end else begin
                        state_r   <= ST_LO;
                    end
                end
                ST_CHK: begin
                    if (accept_s) begin
                        tx_valid_r <= 1'b0;
                        seq_r      <= seq_r + SEQ_W'(1);
                        state_r    <= ST_IDLE;
                    end else begin
                        state_r    <= ST_CHK;
                    end
                end
`else
                ST_LO: begin
                    if (accept_s) begin
                        tx_valid_r <= 1'b0;
                        seq_r      <= seq_r + SEQ_W'(1);
                        state_r    <= ST_IDLE;
                    end else begin
                        state_r    <= ST_LO;
                    end
                end
`endif
                default: begin
                    tx_valid_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx.tx_data  = tx_data_r;
    assign tx.tx_valid = tx_valid_r;
    assign ovf_pulse   = ovf_pulse_r;
    assign ovf_flag    = ovf_flag_r;
endmodule

// File: tb/tb_sample_uart_framer.sv
// Directed self-checking bench for sample_uart_framer (FIFO_DEPTH=4).
module tb_sample_uart_framer;
`ifdef FRAMER_CHECKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b0;
    logic [9:0] sample = 10'h000;
    logic       ovf_pulse;
    logic       ovf_flag;
    logic [2:0] fifo_level;
    int         errors = 0;
    int         checks = 0;

    sample_uart_framer_if tx_if ();

    sample_uart_framer #(.FIFO_DEPTH(4), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .sample     (sample),
        .tx         (tx_if),
        .ovf_pulse  (ovf_pulse),
        .ovf_flag   (ovf_flag),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        ce  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Returns the next byte accepted on the stream (bounded wait)
    task automatic recv_byte(output logic [7:0] b);
        bit got;
        got = 1'b0;
        b   = 8'h00;
        for (int k = 0; k < 200 && !got; k++) begin
            if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b1) begin
                b   = tx_if.tx_data;
                got = 1'b1;
            end
            tick();
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL recv_timeout: no byte accepted within 200 cycles");
        end
    endtask

    task automatic push_one(input logic [9:0] s);
        ce     = 1'b1;
        sample = s;
        tick();
        ce     = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            if (tx_if.tx_valid === 1'b0 && fifo_level === 3'd0) done = 1'b1;
            else tick();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_idle: valid=%b level=%0d required idle", tx_if.tx_valid, fifo_level);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 5;
        if (tx_if.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b need 0", tx_if.tx_valid); end
        if (tx_if.tx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h need 00", tx_if.tx_data); end
        if (ovf_pulse !== 1'b0) begin errors++; $display("FAIL rst_ovf_pulse: got %b need 0", ovf_pulse); end
        if (ovf_flag !== 1'b0) begin errors++; $display("FAIL rst_ovf_flag: got %b need 0", ovf_flag); end
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d need 0", fifo_level); end
    endtask

    task automatic test_single();
        logic [7:0] exp [4];
        logic [7:0] b;
        exp = '{8'hA5, 8'h03, 8'hFF, 8'h59};
        tx_if.tx_ready = 1'b1;
        push_one(10'h3FF);
        checks++;
        if (tx_if.tx_valid !== 1'b0) begin errors++; $display("FAIL single_lat1: valid=%b need 0", tx_if.tx_valid); end
        tick();
        checks += 2;
        if (tx_if.tx_valid !== 1'b1) begin errors++; $display("FAIL single_lat2: valid=%b need 1", tx_if.tx_valid); end
        if (tx_if.tx_data !== 8'hA5) begin errors++; $display("FAIL single_first: data=%h need a5", tx_if.tx_data); end
        for (int i = 0; i < NB; i++) begin
            recv_byte(b);
            checks++;
            if (b !== exp[i]) begin errors++; $display("FAIL single_byte%0d: got %h need %h", i, b, exp[i]); end
        end
        wait_idle();
    endtask

    task automatic test_second();
        logic [7:0] exp [4];
        logic [7:0] b;
        exp = '{8'hA5, 8'h11, 8'h00, 8'hB4};
        push_one(10'h100);
        for (int i = 0; i < NB; i++) begin
            recv_byte(b);
            checks++;
            if (b !== exp[i]) begin errors++; $display("FAIL second_byte%0d: got %h need %h", i, b, exp[i]); end
        end
        wait_idle();
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [4];
        logic [7:0] b;
        exp = '{8'hA5, 8'h22, 8'hAB, 8'h2C};
        push_one(10'h2AB);
        recv_byte(b);
        checks++;
        if (b !== exp[0]) begin errors++; $display("FAIL bp_sync: got %h need %h", b, exp[0]); end
        tx_if.tx_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== exp[1]) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b data=%h need 1/%h", k, tx_if.tx_valid, tx_if.tx_data, exp[1]);
            end
            tick();
        end
        tx_if.tx_ready = 1'b1;
        for (int i = 1; i < NB; i++) begin
            recv_byte(b);
            checks++;
            if (b !== exp[i]) begin errors++; $display("FAIL bp_byte%0d: got %h need %h", i, b, exp[i]); end
        end
        wait_idle();
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        logic [7:0] exp [4];
        apply_reset();
        tx_if.tx_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            ce     = 1'b1;
            sample = 10'(i);
            tick();
            if (i < 6) begin
                checks++;
                if (ovf_pulse !== 1'b0) begin errors++; $display("FAIL ovf_early%0d: pulse=%b need 0", i, ovf_pulse); end
            end
        end
        ce = 1'b0;
        checks += 3;
        if (ovf_pulse !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b need 1", ovf_pulse); end
        if (ovf_flag !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b need 1", ovf_flag); end
        if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d need 4", fifo_level); end
        tick();
        checks += 2;
        if (ovf_pulse !== 1'b0) begin errors++; $display("FAIL ovf_pulse_end: got %b need 0", ovf_pulse); end
        if (ovf_flag !== 1'b1) begin errors++; $display("FAIL ovf_flag_sticky: got %b need 1", ovf_flag); end
        tx_if.tx_ready = 1'b1;
        for (int f = 1; f <= 5; f++) begin
            exp[0] = 8'hA5;
            exp[1] = {4'(f - 1), 4'h0};
            exp[2] = 8'(f);
            exp[3] = exp[0] ^ exp[1] ^ exp[2];
            for (int i = 0; i < NB; i++) begin
                recv_byte(b);
                checks++;
                if (b !== exp[i]) begin errors++; $display("FAIL ovf_frame%0d_byte%0d: got %h need %h", f, i, b, exp[i]); end
            end
        end
        wait_idle();
        tick();
        tick();
        checks++;
        if (tx_if.tx_valid !== 1'b0) begin errors++; $display("FAIL ovf_no_sixth: valid=%b need 0", tx_if.tx_valid); end
    endtask

    task automatic test_seq_wrap();
        logic [7:0] b;
        logic [7:0] exp [4];
        logic [9:0] s;
        apply_reset();
        tx_if.tx_ready = 1'b1;
        for (int f = 0; f < 17; f++) begin
            s      = 10'((f * 71 + 3) % 1024);
            exp[0] = 8'hA5;
            exp[1] = {4'(f % 16), 2'b00, s[9:8]};
            exp[2] = s[7:0];
            exp[3] = exp[0] ^ exp[1] ^ exp[2];
            push_one(s);
            for (int i = 0; i < NB; i++) begin
                recv_byte(b);
                checks++;
                if (b !== exp[i]) begin errors++; $display("FAIL wrap_frame%0d_byte%0d: got %h need %h", f, i, b, exp[i]); end
            end
            wait_idle();
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        logic [7:0] exp [4];
        exp = '{8'hA5, 8'h01, 8'h55, 8'hF1};
        apply_reset();
        tx_if.tx_ready = 1'b0;
        push_one(10'h0C3);
        push_one(10'h111);
        push_one(10'h222);
        tx_if.tx_ready = 1'b1;
        tick();
        tick();
        tx_if.tx_ready = 1'b0;
        checks += 2;
        if (tx_if.tx_data !== 8'hC3) begin errors++; $display("FAIL mid_lo: data=%h need c3", tx_if.tx_data); end
        if (fifo_level !== 3'd2) begin errors++; $display("FAIL mid_level: got %0d need 2", fifo_level); end
        rst = 1'b1;
        tick();
        checks += 3;
        if (tx_if.tx_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b need 0", tx_if.tx_valid); end
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_rst_level: got %0d need 0", fifo_level); end
        if (ovf_flag !== 1'b0) begin errors++; $display("FAIL mid_rst_flag: got %b need 0", ovf_flag); end
        rst = 1'b0;
        tx_if.tx_ready = 1'b1;
        push_one(10'h155);
        for (int i = 0; i < NB; i++) begin
            recv_byte(b);
            checks++;
            if (b !== exp[i]) begin errors++; $display("FAIL mid_after_byte%0d: got %h need %h", i, b, exp[i]); end
        end
        wait_idle();
    endtask

    initial begin
        tx_if.tx_ready = 1'b0;
        test_reset();
        test_single();
        test_second();
        test_backpressure();
        test_overflow();
        test_seq_wrap();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
